// File: rtl/ram_pipelined.sv
// Synchronous data memory with byte-lane writes, post-reset clear
// engine and a 1..4 stage registered read pipeline.
module ram_pipelined #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 65536,
  parameter int                    READ_LATENCY = 1,
  parameter bit                    INIT_CLEAR   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    select,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    addr_error
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a positive multiple of 8");
  end
  if (DEPTH < 1 || $clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam state_t START = INIT_CLEAR ? CLEAR : RUN;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0] clr_cnt;
  logic          clr_last;
  logic          in_range;
  logic [IW-1:0] idx;
  logic          acc;
  logic          rd;
  logic          wr_ok;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic [READ_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  assign clr_last = (clr_cnt == IW'(DEPTH - 1));
  assign in_range = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = address[IW-1:0];
  assign acc      = select & ready;
  assign rd       = acc & ~write;
  assign wr_ok    = acc & write & in_range;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= START;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (clr_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ready = (state == RUN) && !reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + IW'(1);
  end

  // The array itself carries no reset; the clear engine owns it until RUN.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  assign rd_word = in_range ? mem[idx] : '0;

  // Data only moves with its valid bit, so the last stage holds when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv         <= '0;
      addr_error <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0]      <= rd;
      addr_error <= acc & ~in_range;
      if (rd) pd[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign data_valid = pv[READ_LATENCY-1];
  assign data_out   = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_pipelined.sv
// Bench for ram_pipelined: two configurations on one stimulus bus,
// directed tables/sequences plus random traffic against a model.
module tb_ram_pipelined;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        wr;
  logic [3:0]  be;
  logic [4:0]  a;
  logic [31:0] din;

  logic        r0, dv0, ae0;
  logic [31:0] do0;
  logic        r1, dv1, ae1;
  logic [31:0] do1;

  int checks = 0;
  int errors = 0;

  ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(1), .INIT_CLEAR(1'b1),
    .CLEAR_VALUE(32'hDEADBEEF)
  ) u0 (
    .clock(clk), .reset(rst), .select(sel), .write(wr),
    .byte_en(be), .address(a), .data_in(din),
    .ready(r0), .data_out(do0), .data_valid(dv0),
    .addr_error(ae0)
  );

  ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12),
    .READ_LATENCY(3), .INIT_CLEAR(1'b1),
    .CLEAR_VALUE(32'h0)
  ) u1 (
    .clock(clk), .reset(rst), .select(sel), .write(wr),
    .byte_en(be), .address(a[3:0]), .data_in(din),
    .ready(r1), .data_out(do1), .data_valid(dv1),
    .addr_error(ae1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic logic [31:0] cv(input int k);
    return (k == 0) ? 32'hDEADBEEF : 32'h0;
  endfunction

  // Reference model: memory contents plus a scoreboard of read results
  // keyed by the edge number at which each result becomes visible.
  logic [31:0] mm [2][16];
  int          cyc [2];
  bit          run [2];
  bit          sv [2][64];
  logic [31:0] sd [2][64];
  bit          e_v [2];
  logic [31:0] e_d [2];
  bit          e_e [2];
  int          eno = 0;
  int          ad;
  int          slot;

  always @(posedge clk) begin
    eno++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cyc[k] = 0;
        run[k] = 0;
        e_v[k] = 0;
        e_d[k] = 32'h0;
        e_e[k] = 0;
        for (int j = 0; j < 64; j++) sv[k][j] = 0;
      end else begin
        ad = (k == 0) ? int'(a) : int'(a[3:0]);
        e_e[k] = 0;
        if (!run[k]) begin
          cyc[k]++;
          if (cyc[k] == dep(k)) begin
            run[k] = 1;
            for (int j = 0; j < 16; j++) mm[k][j] = cv(k);
          end
        end else if (sel) begin
          slot = (eno + lat(k) - 1) % 64;
          if (ad < dep(k)) begin
            if (wr) begin
              for (int b = 0; b < 4; b++)
                if (be[b]) mm[k][ad][8*b +: 8] = din[8*b +: 8];
            end else begin
              sv[k][slot] = 1;
              sd[k][slot] = mm[k][ad];
            end
          end else begin
            e_e[k] = 1;
            if (!wr) begin
              sv[k][slot] = 1;
              sd[k][slot] = 32'h0;
            end
          end
        end
        e_v[k] = sv[k][eno % 64];
        if (e_v[k]) e_d[k] = sd[k][eno % 64];
        sv[k][eno % 64] = 0;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("rdy0", 32'(r0), 32'(run[0] && !rst));
    chk("rdy1", 32'(r1), 32'(run[1] && !rst));
    chk("val0", 32'(dv0), 32'(e_v[0]));
    chk("val1", 32'(dv1), 32'(e_v[1]));
    chk("err0", 32'(ae0), 32'(e_e[0]));
    chk("err1", 32'(ae1), 32'(e_e[1]));
    chk("dout0", do0, e_d[0]);
    chk("dout1", do1, e_d[1]);
  endtask

  task automatic drive(input logic s, input logic w,
                       input logic [3:0] b, input logic [4:0] ad_i,
                       input logic [31:0] d);
    sel = s;
    wr  = w;
    be  = b;
    a   = ad_i;
    din = d;
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [3:0]  be;
    logic [4:0]  a;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tv [13];
  int   n0, n1, nv;
  bit   rv [6];
  logic [31:0] rd_d [6];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 4'hF, 5'd0,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 4'hF, 5'd15, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 4'hF, 5'd3,  32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 4'hF, 5'd3,  32'h0,        1'b1, 32'h12345678, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 4'hF, 5'd5,  32'hFFFFFFFF, 1'b0, 32'h12345678, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 4'h1, 5'd5,  32'h000000AA, 1'b0, 32'h12345678, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 4'h0, 5'd5,  32'h0,        1'b1, 32'hFFFFFFAA, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 4'h0, 5'd5,  32'h0,        1'b0, 32'hFFFFFFAA, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 4'hF, 5'd5,  32'h0,        1'b1, 32'hFFFFFFAA, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 4'hF, 5'd20, 32'h11111111, 1'b0, 32'hFFFFFFAA, 1'b1};
    tv[10] = '{1'b1, 1'b0, 4'hF, 5'd20, 32'h0,        1'b1, 32'h0,        1'b1};
    tv[11] = '{1'b0, 1'b0, 4'hF, 5'd3,  32'h0,        1'b0, 32'h0,        1'b0};
    tv[12] = '{1'b1, 1'b0, 4'hF, 5'd3,  32'h0,        1'b1, 32'h12345678, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    step();
    step();
    chk("reset_ready", 32'({r0, r1}), 32'h0);
    chk("reset_valid", 32'({dv0, dv1}), 32'h0);
    chk("reset_err", 32'({ae0, ae1}), 32'h0);
    chk("reset_dout", do0 | do1, 32'h0);

    // Clear length after reset release
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (!r0) n0++;
      if (!r1) n1++;
      step();
    end
    chk("clear_len0", 32'(n0), 32'd16);
    chk("clear_len1", 32'(n1), 32'd12);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'hF, 5'(i), 32'h0);
      step();
      chk("clear_val", do0, 32'hDEADBEEF);
      chk("clear_vld", 32'(dv0), 32'h1);
    end

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].s, tv[i].w, tv[i].be, tv[i].a, tv[i].d);
      step();
      chk($sformatf("tv%0d_valid", i), 32'(dv0), 32'(tv[i].ev));
      chk($sformatf("tv%0d_dout", i), do0, tv[i].ed);
      chk($sformatf("tv%0d_err", i), 32'(ae0), 32'(tv[i].ee));
    end

    // Latency-3 back-to-back reads
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'hF, 5'(i), 32'(10 + i));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 4'hF, 5'(i), 32'h0);
      else       drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
      step();
      rv[i]   = dv1;
      rd_d[i] = do1;
    end
    chk("l3_valid", 32'({rv[0], rv[1], rv[2], rv[3], rv[4], rv[5]}),
        32'b001110);
    chk("l3_d0", rd_d[2], 32'd10);
    chk("l3_d1", rd_d[3], 32'd11);
    chk("l3_d2", rd_d[4], 32'd12);

    // Out-of-range on the 12-word instance
    drive(1'b1, 1'b1, 4'hF, 5'd13, 32'h77777777);
    step();
    chk("oor_wr_err", 32'(ae1), 32'h1);
    drive(1'b1, 1'b0, 4'hF, 5'd13, 32'h0);
    step();
    chk("oor_rd_err", 32'(ae1), 32'h1);
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    step();
    chk("oor_err_pulse", 32'(ae1), 32'h0);
    step();
    chk("oor_rd_vld", 32'(dv1), 32'h1);
    chk("oor_rd_data", do1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom),
            4'($urandom), 5'($urandom_range(0, 31)), $urandom);
      step();
    end

    // Reset in the middle of the clear sweep
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (!r0) n0++;
      if (!r1) n1++;
      step();
    end
    chk("reclear_len0", 32'(n0), 32'd16);
    chk("reclear_len1", 32'(n1), 32'd12);

    // Reset with two reads in flight
    drive(1'b1, 1'b0, 4'hF, 5'd0, 32'h0);
    step();
    drive(1'b1, 1'b0, 4'hF, 5'd1, 32'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (dv0 || dv1) nv++;
      step();
      rst = 1'b0;
    end
    chk("flush_valid", 32'(nv), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
